// File: rtl/mic_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mic_frame_scheduler                                          |
// | Description : Serialises a parallel 6-channel microphone sample set into   |
// |               a channel-tagged valid/ready stream, skipping masked-off     |
// |               channels and counting frames that arrive while busy.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mic_frame_scheduler #(
  parameter int DATA_W  = 24,
  parameter int NUM_MIC = 6,
  parameter int CH_W    = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_MIC-1:0] ch_mask,
  input  logic [DATA_W-1:0] mic0_data_i,
  input  logic [DATA_W-1:0] mic1_data_i,
  input  logic [DATA_W-1:0] mic2_data_i,
  input  logic [DATA_W-1:0] mic3_data_i,
  input  logic [DATA_W-1:0] mic4_data_i,
  input  logic [DATA_W-1:0] mic5_data_i,
  input  logic              mic_data_vld_i,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              overrun_o,
  input  logic              overrun_clr,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  ovr_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [NUM_MIC-1:0]        mask_q, mask_d;
  logic [DATA_W-1:0]         shadow_q [NUM_MIC];
  logic [DATA_W-1:0]         shadow_d [NUM_MIC];
  logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]          ovr_cnt_q, ovr_cnt_d;
  logic                      overrun_q, overrun_d;

  logic [DATA_W-1:0]         w_mic [NUM_MIC];
  logic [DATA_W-1:0]         w_sel_data;
  logic                      w_more;
  logic                      w_accept;
  logic                      w_hs;
  logic                      w_final;
  logic                      w_ovr_evt;

  // Lowest set bit of mask at or above index lo (caller guarantees one exists).
  function automatic logic [CH_W-1:0] lowest_from(input logic [NUM_MIC-1:0] mask,
                                                  input int lo);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_MIC - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) r = CH_W'(i);
    end
    return r;
  endfunction

  // Gather the driver inputs into an indexable array.
  always_comb begin
    w_mic[0] = mic0_data_i;
    w_mic[1] = mic1_data_i;
    w_mic[2] = mic2_data_i;
    w_mic[3] = mic3_data_i;
    w_mic[4] = mic4_data_i;
    w_mic[5] = mic5_data_i;
  end

  // Current-beat data select and "any higher channel left" detection.
  always_comb begin
    w_sel_data = '0;
    w_more     = 1'b0;
    for (int i = 0; i < NUM_MIC; i++) begin
      if (ch_q == CH_W'(i)) w_sel_data = shadow_q[i];
      if (mask_q[i] && (i > int'(ch_q))) w_more = 1'b1;
    end
  end

  assign busy      = (state_q == SEND);
  assign m_valid   = busy;
  assign m_ch      = ch_q;
  assign m_data    = busy ? w_sel_data : '0;
  assign m_last    = busy && !w_more;
  assign overrun_o = overrun_q;
  assign frame_cnt = frame_cnt_q;
  assign ovr_cnt   = ovr_cnt_q;

  assign w_accept  = mic_data_vld_i && en && (|ch_mask);
  assign w_hs      = m_valid && m_ready;
  assign w_final   = w_hs && m_last;
  // A new frame while draining is only absorbed on the final beat's handshake.
  assign w_ovr_evt = busy && w_accept && !w_final;

  // Next-state, channel walk, frame latch and counters.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    shadow_d    = shadow_q;
    frame_cnt_d = frame_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          shadow_d = w_mic;
          mask_d   = ch_mask;
          ch_d     = lowest_from(ch_mask, 0);
          state_d  = SEND;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (m_last) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (w_accept) begin
              shadow_d = w_mic;
              mask_d   = ch_mask;
              ch_d     = lowest_from(ch_mask, 0);
            end else begin
              state_d = IDLE;
            end
          end else begin
            ch_d = lowest_from(mask_q, int'(ch_q) + 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting the overrun flag takes priority over a simultaneous clear.
    if (w_ovr_evt) begin
      overrun_d = 1'b1;
      if (overrun_clr) begin
        ovr_cnt_d = CNT_W'(1);
      end else if (ovr_cnt_q != {CNT_W{1'b1}}) begin
        ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
      end
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
      ovr_cnt_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      mask_q      <= '0;
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_MIC; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < NUM_MIC; i++) shadow_q[i] <= shadow_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mic_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mic_frame_scheduler                                       |
// | Description : Directed plus random stimulus against a beat-queue model of  |
// |               the frame scheduler.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mic_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  ch_mask;
  logic [23:0] mic [6];
  logic        vld;
  logic        m_ready;
  logic        overrun_clr;
  logic [23:0] m_data;
  logic [2:0]  m_ch;
  logic        m_last;
  logic        m_valid;
  logic        busy;
  logic        overrun_o;
  logic [15:0] frame_cnt;
  logic [15:0] ovr_cnt;

  always #5 clk = ~clk;

  mic_frame_scheduler #(
    .DATA_W(24), .NUM_MIC(6), .CH_W(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask),
    .mic0_data_i(mic[0]), .mic1_data_i(mic[1]), .mic2_data_i(mic[2]),
    .mic3_data_i(mic[3]), .mic4_data_i(mic[4]), .mic5_data_i(mic[5]),
    .mic_data_vld_i(vld),
    .m_data(m_data), .m_ch(m_ch), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .overrun_o(overrun_o),
    .overrun_clr(overrun_clr), .frame_cnt(frame_cnt), .ovr_cnt(ovr_cnt)
  );

  typedef struct packed {
    logic [23:0] d;
    logic [2:0]  ch;
    logic        last;
  } beat_t;

  // Reference model: the beats still owed to the consumer, plus the status.
  beat_t       q[$];
  logic        e_ovr;
  logic [15:0] e_ocnt;
  logic [15:0] e_fcnt;
  bit          in_reset;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() != 0);
    chk("m_valid", 32'(m_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(ev));
    chk("overrun_o", 32'(overrun_o), 32'(e_ovr));
    chk("ovr_cnt", 32'(ovr_cnt), 32'(e_ocnt));
    chk("frame_cnt", 32'(frame_cnt), 32'(e_fcnt));
    if (ev) begin
      chk("m_data", 32'(m_data), 32'(q[0].d));
      chk("m_ch", 32'(m_ch), 32'(q[0].ch));
      chk("m_last", 32'(m_last), 32'(q[0].last));
    end
    if (in_reset) begin
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_ch", 32'(m_ch), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit ev, hs, fin, acc, ov_ev;
    beat_t b;
    if (rst) begin
      q.delete();
      e_ovr  = 1'b0;
      e_ocnt = '0;
      e_fcnt = '0;
      return;
    end
    ev    = (q.size() != 0);
    hs    = ev && m_ready;
    fin   = hs && q[0].last;
    acc   = vld && en && (ch_mask != 6'd0);
    ov_ev = acc && ev && !fin;
    if (hs) void'(q.pop_front());
    if (fin) e_fcnt = e_fcnt + 16'd1;
    if (ov_ev) begin
      e_ovr  = 1'b1;
      e_ocnt = overrun_clr ? 16'd1 : ((e_ocnt == 16'hFFFF) ? e_ocnt : e_ocnt + 16'd1);
    end else if (overrun_clr) begin
      e_ovr  = 1'b0;
      e_ocnt = '0;
    end
    if (acc && !ov_ev) begin
      for (int i = 0; i < 6; i++) begin
        if (ch_mask[i]) begin
          b.d    = mic[i];
          b.ch   = 3'(i);
          b.last = ((ch_mask >> (i + 1)) == 6'd0);
          q.push_back(b);
        end
      end
    end
  endtask

  // One clock: check mid-cycle, step the model, then drop single-cycle pulses.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
    vld         = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic rand_samples();
    for (int i = 0; i < 6; i++) mic[i] = 24'($urandom());
  endtask

  initial begin
    bit did_b2b;
    rst = 1'b1; en = 1'b1; ch_mask = 6'h3F; vld = 1'b0;
    m_ready = 1'b1; overrun_clr = 1'b0;
    e_ovr = 1'b0; e_ocnt = '0; e_fcnt = '0;
    rand_samples();
    in_reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset held for 3 clocks with frame pulses present.
    for (int k = 0; k < 3; k++) begin
      vld = 1'b1;
      rand_samples();
      cycle();
    end
    rst = 1'b0;
    in_reset = 1'b0;
    cycle();

    // Full frame, samples 1..6, consumer always ready.
    ch_mask = 6'h3F;
    for (int i = 0; i < 6; i++) mic[i] = 24'(i + 1);
    m_ready = 1'b1;
    vld = 1'b1;
    cycle();
    repeat (7) cycle();

    // Sparse mask with the consumer toggling ready.
    ch_mask = 6'b100101;
    rand_samples();
    vld = 1'b1;
    cycle();
    for (int k = 0; k < 8; k++) begin
      m_ready = k[0];
      cycle();
    end
    m_ready = 1'b1;
    repeat (3) cycle();

    // Overrun while stalled, then clear coinciding with a new overrun.
    ch_mask = 6'h3F;
    m_ready = 1'b0;
    rand_samples();
    vld = 1'b1;
    cycle();
    repeat (2) cycle();
    rand_samples();
    vld = 1'b1;
    cycle();
    cycle();
    rand_samples();
    vld = 1'b1;
    overrun_clr = 1'b1;
    cycle();
    cycle();
    m_ready = 1'b1;
    repeat (8) cycle();
    overrun_clr = 1'b1;
    cycle();
    cycle();

    // Back-to-back: new frame on the last beat's handshake.
    rand_samples();
    vld = 1'b1;
    cycle();
    did_b2b = 1'b0;
    for (int k = 0; k < 10 && !did_b2b; k++) begin
      if (q.size() == 1) begin
        rand_samples();
        ch_mask = 6'b011010;
        vld = 1'b1;
        did_b2b = 1'b1;
      end
      cycle();
    end
    chk("b2b_reached", 32'(did_b2b), 32'd1);
    repeat (5) cycle();

    // Gating: disabled scheduler and empty mask are ignored; en drop mid-frame.
    ch_mask = 6'h3F;
    en = 1'b0;
    vld = 1'b1;
    cycle();
    en = 1'b1;
    ch_mask = 6'd0;
    vld = 1'b1;
    cycle();
    cycle();
    ch_mask = 6'h3F;
    rand_samples();
    vld = 1'b1;
    cycle();
    en = 1'b0;
    repeat (8) cycle();
    en = 1'b1;

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      rand_samples();
      vld         = ($urandom() % 4) == 0;
      en          = ($urandom() % 8) != 0;
      ch_mask     = 6'($urandom());
      m_ready     = ($urandom() % 3) != 0;
      overrun_clr = ($urandom() % 16) == 0;
      cycle();
    end
    m_ready = 1'b1;
    repeat (8) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
